// File: rtl/traffic_ctrl_param.sv
// traffic_ctrl_param: highway/local road signal controller with flash mode
module traffic_ctrl_param #(
  parameter int HWY_MIN_GRN = 16,
  parameter int Y2R_DEL     = 3,
  parameter int R2G_DEL     = 2,
  parameter int LCL_MAX_GRN = 32,
  parameter int FLASH_HALF  = 8,
  parameter int TW          = 8
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       X,
  input  logic       flash,
  output logic [1:0] hwy,
  output logic [1:0] lcl,
  output logic [2:0] state,
  output logic       tmo
);
  localparam logic [2:0] S_HG  = 3'd0;
  localparam logic [2:0] S_HY  = 3'd1;
  localparam logic [2:0] S_AR1 = 3'd2;
  localparam logic [2:0] S_LG  = 3'd3;
  localparam logic [2:0] S_LY  = 3'd4;
  localparam logic [2:0] S_AR2 = 3'd5;
  localparam logic [2:0] S_FL  = 3'd6;
  localparam logic [1:0] RED = 2'b00, YEL = 2'b01, GRN = 2'b10, OFF = 2'b11;
  localparam logic [TW-1:0] T_HG = TW'(HWY_MIN_GRN - 1);
  localparam logic [TW-1:0] T_Y  = TW'(Y2R_DEL - 1);
  localparam logic [TW-1:0] T_R  = TW'(R2G_DEL - 1);
  localparam logic [TW-1:0] T_L  = TW'(LCL_MAX_GRN - 1);
  localparam logic [TW-1:0] T_F  = TW'(FLASH_HALF - 1);
  logic [2:0]    r_state, w_nxt;
  logic [TW-1:0] r_timer, w_load;
  logic          r_req, r_phase, r_tmo;
  logic          w_t0, w_enter;
  assign w_t0    = r_timer == '0;
  assign w_enter = w_nxt != r_state;
  // next state: flash overrides everything, otherwise timer/car driven sequence
  always_comb begin
    w_nxt = r_state;
    if (flash) w_nxt = S_FL;
    else
      case (r_state)
        S_HG:    w_nxt = (w_t0 && (r_req || X)) ? S_HY : S_HG;
        S_HY:    w_nxt = w_t0 ? S_AR1 : S_HY;
        S_AR1:   w_nxt = w_t0 ? S_LG : S_AR1;
        S_LG:    w_nxt = (!X || w_t0) ? S_LY : S_LG;
        S_LY:    w_nxt = w_t0 ? S_AR2 : S_LY;
        S_AR2:   w_nxt = w_t0 ? S_HG : S_AR2;
        S_FL:    w_nxt = S_AR2;
        default: w_nxt = S_HG;
      endcase
  end
  // dwell reload value for the state being entered
  always_comb begin
    w_load = (w_nxt == S_HG) ? T_HG :
             (w_nxt == S_HY || w_nxt == S_LY) ? T_Y :
             (w_nxt == S_AR1 || w_nxt == S_AR2) ? T_R :
             (w_nxt == S_LG) ? T_L : T_F;
  end
  // state register
  always_ff @(posedge clk or negedge clr)
    if (!clr) r_state <= S_HG;
    else r_state <= w_nxt;
  // shared down-timer; in flash it recycles each half period
  always_ff @(posedge clk or negedge clr)
    if (!clr) r_timer <= T_HG;
    else if (w_enter) r_timer <= w_load;
    else if (r_state == S_FL && w_t0) r_timer <= T_F;
    else if (!w_t0) r_timer <= r_timer - TW'(1);
  // local-car request latch, dropped once local green or flash is granted
  always_ff @(posedge clk or negedge clr)
    if (!clr) r_req <= 1'b0;
    else r_req <= (w_nxt == S_LG || w_nxt == S_FL) ? 1'b0 : (r_state == S_HG && X) ? 1'b1 : r_req;
  // flash phase: zero on entry, toggles at each half-period expiry
  always_ff @(posedge clk or negedge clr)
    if (!clr) r_phase <= 1'b0;
    else r_phase <= (r_state == S_FL && w_nxt == S_FL) ? r_phase ^ w_t0 : 1'b0;
  // timeout flag for the first yellow cycle after a max-green local exit
  always_ff @(posedge clk or negedge clr)
    if (!clr) r_tmo <= 1'b0;
    else r_tmo <= r_state == S_LG && w_nxt == S_LY && X && w_t0;
  assign hwy   = (r_state == S_HG) ? GRN : (r_state == S_HY) ? YEL :
                 (r_state == S_FL) ? (r_phase ? OFF : YEL) : RED;
  assign lcl   = (r_state == S_LG) ? GRN : (r_state == S_LY) ? YEL :
                 (r_state == S_FL && r_phase) ? OFF : RED;
  assign state = r_state;
  assign tmo   = r_tmo;
endmodule

// File: tb/tb_traffic_ctrl_param.sv
// tb_traffic_ctrl_param: directed and random checks against an elapsed-cycle model
module tb_traffic_ctrl_param;
  localparam int P_HG = 4, P_Y = 3, P_R = 2, P_L = 8, P_F = 2;
  localparam int HG = 0, HY = 1, AR1 = 2, LG = 3, LY = 4, AR2 = 5, FL = 6;
  logic clk = 1'b0, clr = 1'b0, X = 1'b0, flash = 1'b0;
  logic [1:0] hwy, lcl;
  logic [2:0] state;
  logic tmo;
  int total = 0, bad = 0;
  int m_st, m_cnt;
  bit m_req, m_tmo;
  bit rx, rf;
  traffic_ctrl_param #(.HWY_MIN_GRN(P_HG), .Y2R_DEL(P_Y), .R2G_DEL(P_R),
    .LCL_MAX_GRN(P_L), .FLASH_HALF(P_F), .TW(8)) dut (
    .clk(clk), .clr(clr), .X(X), .flash(flash),
    .hwy(hwy), .lcl(lcl), .state(state), .tmo(tmo));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] a, input logic [7:0] e);
    total++;
    assert (a === e) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, a, e);
    end
  endtask
  task automatic m_reset();
    m_st = HG; m_cnt = 1; m_req = 0; m_tmo = 0;
  endtask
  task automatic m_step(input bit x, input bit f);
    int nx;
    nx = m_st;
    if (f) nx = FL;
    else
      case (m_st)
        HG:  if (m_cnt >= P_HG && (m_req || x)) nx = HY;
        HY:  if (m_cnt >= P_Y) nx = AR1;
        AR1: if (m_cnt >= P_R) nx = LG;
        LG:  if (!x || m_cnt >= P_L) nx = LY;
        LY:  if (m_cnt >= P_Y) nx = AR2;
        AR2: if (m_cnt >= P_R) nx = HG;
        default: nx = AR2;
      endcase
    m_tmo = m_st == LG && nx == LY && x && m_cnt >= P_L;
    if (nx == LG || nx == FL) m_req = 0;
    else if (m_st == HG && x) m_req = 1;
    m_cnt = (nx == m_st) ? m_cnt + 1 : 1;
    m_st = nx;
  endtask
  task automatic check_all();
    logic [1:0] eh, el;
    bit ph;
    ph = ((m_cnt - 1) / P_F) % 2 == 1;
    case (m_st)
      HG:      begin eh = 2; el = 0; end
      HY:      begin eh = 1; el = 0; end
      LG:      begin eh = 0; el = 2; end
      LY:      begin eh = 0; el = 1; end
      FL:      begin eh = ph ? 2'd3 : 2'd1; el = ph ? 2'd3 : 2'd0; end
      default: begin eh = 0; el = 0; end
    endcase
    chk("state", {5'd0, state}, 8'(m_st));
    chk("hwy", {6'd0, hwy}, {6'd0, eh});
    chk("lcl", {6'd0, lcl}, {6'd0, el});
    chk("tmo", {7'd0, tmo}, {7'd0, m_tmo});
    chk("safe", {7'd0, hwy != 0 && lcl != 0 && !(hwy == 3 && lcl == 3)}, 8'd0);
  endtask
  task automatic cyc(input bit x, input bit f);
    X = x; flash = f;
    @(posedge clk);
    m_step(x, f);
    #1 check_all();
  endtask
  task automatic do_reset();
    #2 clr = 1'b0;
    #1 m_reset();
    chk("rst_state", {5'd0, state}, 8'd0);
    chk("rst_hwy", {6'd0, hwy}, 8'd2);
    chk("rst_lcl", {6'd0, lcl}, 8'd0);
    chk("rst_tmo", {7'd0, tmo}, 8'd0);
    @(posedge clk);
    #3 clr = 1'b1;
  endtask
  initial begin
    m_reset();
    #1 check_all();
    do_reset();
    repeat (4 + 3 + 2 + 8 + 3 + 2 + 4) cyc(1, 0);
    do_reset();
    repeat (100) cyc(0, 0);
    do_reset();
    cyc(0, 0);
    cyc(1, 0);
    repeat (10) cyc(0, 0);
    do_reset();
    repeat (9) cyc(1, 0);
    repeat (2) cyc(1, 0);
    repeat (8) cyc(0, 0);
    do_reset();
    repeat (11) cyc(1, 0);
    repeat (9) cyc(1, 1);
    repeat (5) cyc(0, 0);
    do_reset();
    repeat (5) cyc(1, 0);
    do_reset();
    repeat (8) cyc(1, 0);
    rf = 0;
    for (int i = 0; i < 1500; i++) begin
      rx = $urandom_range(0, 9) < 6;
      if ($urandom_range(0, 39) == 0) rf = !rf;
      if ($urandom_range(0, 199) == 0) do_reset();
      cyc(rx, rf);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
